// File: rtl/dmux8way16_reg_if.sv
// Producer and per-lane consumer bus for dmux8way16_reg.
// The bcast signal exists only when DMUX_BROADCAST_EN is defined.
interface dmux8way16_reg_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in;
    logic [2:0]       sel;
    logic             in_valid;
    logic             in_ready;
`ifdef DMUX_BROADCAST_EN
    logic             bcast;
`endif
    logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [CNT_W-1:0] count;

    modport master (
`ifdef DMUX_BROADCAST_EN
        output bcast,
`endif
        output in, sel, in_valid, out_ready,
        input  in_ready, o0, o1, o2, o3, o4, o5, o6, o7, out_valid, count
    );

    modport slave (
`ifdef DMUX_BROADCAST_EN
        input  bcast,
`endif
        input  in, sel, in_valid, out_ready,
        output in_ready, o0, o1, o2, o3, o4, o5, o6, o7, out_valid, count
    );
endinterface

// File: rtl/dmux8way16_reg.sv
// Registered 1-to-8 word demux: one holding register per lane, each with its own valid/ready.
// Optional broadcast to all lanes is enabled by defining DMUX_BROADCAST_EN.
module dmux8way16_reg_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // A load always wins over a drain: that is the pass-through refill case.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == FULL);
    end

    // Data is not cleared on drain; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

module dmux8way16_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    dmux8way16_reg_if.slave   bus
);
    localparam int NUM_LANES = 8;

    logic [NUM_LANES-1:0][WIDTH-1:0] q;
    logic [NUM_LANES-1:0]            vld;
    logic [NUM_LANES-1:0]            free;
    logic [NUM_LANES-1:0]            load;
    logic                            rdy;
    logic                            accept;
    logic [CNT_W-1:0]                cnt;

    // A lane can take a word if it is empty or being drained this same cycle.
    assign free = ~vld | bus.out_ready;

`ifdef DMUX_BROADCAST_EN
    assign rdy = bus.bcast ? (&free) : free[bus.sel];
`else
    assign rdy = free[bus.sel];
`endif

    assign accept = bus.in_valid & rdy;

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
`ifdef DMUX_BROADCAST_EN
            assign load[k] = accept & (bus.bcast | (bus.sel == 3'(k)));
`else
            assign load[k] = accept & (bus.sel == 3'(k));
`endif
            dmux8way16_reg_lane #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .reset (reset),
                .load  (load[k]),
                .ready (bus.out_ready[k]),
                .d     (bus.in),
                .q     (q[k]),
                .valid (vld[k])
            );
        end
    endgenerate

    // One increment per accepted word, broadcast included.
    always_ff @(posedge clk) begin
        if (reset)       cnt <= '0;
        else if (accept) cnt <= cnt + CNT_W'(1);
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.count     = cnt;
    assign bus.o0 = q[0];
    assign bus.o1 = q[1];
    assign bus.o2 = q[2];
    assign bus.o3 = q[3];
    assign bus.o4 = q[4];
    assign bus.o5 = q[5];
    assign bus.o6 = q[6];
    assign bus.o7 = q[7];
endmodule

// File: tb/tb_dmux8way16_reg.sv
// Scoreboard bench for dmux8way16_reg: accepted words are queued per lane and
// a negedge monitor compares each drained word against its lane queue.
module tb_dmux8way16_reg;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] exp_q [8][$];
    logic [15:0] o_arr [8];

    dmux8way16_reg_if #(.WIDTH(16), .CNT_W(16)) bus ();

    dmux8way16_reg #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign o_arr[0] = bus.o0;
    assign o_arr[1] = bus.o1;
    assign o_arr[2] = bus.o2;
    assign o_arr[3] = bus.o3;
    assign o_arr[4] = bus.o4;
    assign o_arr[5] = bus.o5;
    assign o_arr[6] = bus.o6;
    assign o_arr[7] = bus.o7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string name, input logic [7:0] vexp, input logic [15:0] d [8]);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(vexp));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_o%0d", name, k), 32'(o_arr[k]), 32'(d[k]));
    endtask

    // Monitor: every drain must match the oldest word accepted for that lane.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_unexpected lane %0d: got %h, required no word", k, o_arr[k]);
                    end else begin
                        chk($sformatf("drain_lane%0d", k), 32'(o_arr[k]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic offer(input logic [2:0] s, input logic [15:0] d);
        bus.sel      = s;
        bus.in       = d;
        bus.in_valid = 1'b1;
        exp_q[s].push_back(d);
    endtask

    initial begin
        logic [15:0] zeros [8];
        logic [15:0] exp_d [8];
        for (int k = 0; k < 8; k++) zeros[k] = 16'h0000;

        reset         = 1'b1;
        bus.in        = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
`ifdef DMUX_BROADCAST_EN
        bus.bcast     = 1'b0;
`endif
        step();
        step();
        chk_lanes("reset", 8'h00, zeros);
        chk("reset_count", 32'(bus.count), 32'd0);
        reset = 1'b0;

        // First word to lane 3
        offer(3'd3, 16'hA5A5);
        #1 chk("first_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        exp_d = zeros;
        exp_d[3] = 16'hA5A5;
        chk_lanes("first", 8'h08, exp_d);
        chk("first_count", 32'(bus.count), 32'd1);

        // Stall on full lane 3, then retarget to lane 5 before the edge
        bus.sel = 3'd3; bus.in = 16'h1234; bus.in_valid = 1'b1;
        #1 chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("stall_o3", 32'(bus.o3), 32'hA5A5);
        chk("stall_count", 32'(bus.count), 32'd1);
        bus.sel = 3'd3;
        #1 chk("stall2_in_ready", 32'(bus.in_ready), 32'd0);
        offer(3'd5, 16'h1234);
        #1 chk("resel_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("resel_o5", 32'(bus.o5), 32'h1234);
        chk("resel_valid", 32'(bus.out_valid), 32'h28);
        chk("resel_count", 32'(bus.count), 32'd2);

        // Pass-through refill on lane 3
        bus.out_ready = 8'h08;
        offer(3'd3, 16'hBEEF);
        #1 chk("refill_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 8'h00;
        chk("refill_valid", 32'(bus.out_valid), 32'h28);
        chk("refill_o3", 32'(bus.o3), 32'hBEEF);
        chk("refill_count", 32'(bus.count), 32'd3);

        // Empty everything, fill all lanes with 0..7, drain in one cycle
        bus.out_ready = 8'hFF;
        step();
        bus.out_ready = 8'h00;
        chk("empty_valid", 32'(bus.out_valid), 32'h00);
        for (int k = 0; k < 8; k++) begin
            offer(3'(k), 16'(k));
            #1 chk($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_valid", 32'(bus.out_valid), 32'hFF);
        bus.out_ready = 8'hFF;
        step();
        bus.out_ready = 8'h00;
        for (int k = 0; k < 8; k++) exp_d[k] = 16'(k);
        chk_lanes("drainall", 8'h00, exp_d);
        chk("drainall_count", 32'(bus.count), 32'd11);

        // Run count up to 0xFFFF through lane 0 with continuous refill, then wrap
        bus.out_ready = 8'h01;
        for (int i = 0; i < 65524; i++) begin
            offer(3'd0, 16'(i));
            step();
        end
        chk("count_max", 32'(bus.count), 32'hFFFF);
        offer(3'd0, 16'hCAFE);
        step();
        bus.in_valid = 1'b0;
        chk("count_wrap", 32'(bus.count), 32'h0000);
        step();
        bus.out_ready = 8'h00;
        chk("wrap_drained", 32'(bus.out_valid), 32'h00);

        // Reset with full lanes discards their words
        offer(3'd1, 16'h1111);
        step();
        offer(3'd2, 16'h2222);
        step();
        bus.in_valid = 1'b0;
        chk("prereset_valid", 32'(bus.out_valid), 32'h06);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        step();
        reset = 1'b0;
        chk_lanes("midreset", 8'h00, zeros);
        chk("midreset_count", 32'(bus.count), 32'd0);

`ifdef DMUX_BROADCAST_EN
        bus.bcast = 1'b1;
        bus.in = 16'h00FF;
        bus.in_valid = 1'b1;
        #1 chk("bcast_in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            exp_q[k].push_back(16'h00FF);
            exp_d[k] = 16'h00FF;
        end
        step();
        bus.in_valid = 1'b0;
        chk_lanes("bcast", 8'hFF, exp_d);
        chk("bcast_count", 32'(bus.count), 32'd1);
        bus.out_ready = 8'hFB;
        bus.in = 16'h0F0F;
        bus.in_valid = 1'b1;
        #1 chk("bcast_block_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("bcast_block_valid", 32'(bus.out_valid), 32'h04);
        chk("bcast_block_count", 32'(bus.count), 32'd1);
        bus.out_ready = 8'h04;
        step();
        bus.out_ready = 8'h00;
        bus.bcast = 1'b0;
`endif

        step();
        for (int k = 0; k < 8; k++)
            chk($sformatf("undelivered_lane%0d", k), 32'(exp_q[k].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmux8way16_reg.md
Name: dmux8way16_reg

Overview:
- Registered 1-to-8 demultiplexer for 16-bit words, the distributing counterpart of the 8-to-1 word selector in the datapath.
- Takes one input word with a 3-bit destination and a valid/ready handshake.
- Parks the word in a one-entry holding register for the addressed lane.
- Each lane presents its word to its own consumer through a per-lane valid/ready handshake.

Parameters:
- WIDTH, 16, data word width in bits (all data ports and holding registers).
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in  input  WIDTH  input data word
- sel  input  3  destination lane index 0..7
- in_valid  input  1  producer offers in/sel this cycle
- in_ready  output  1  block accepts in/sel this cycle (combinational)
- o0..o7  output  WIDTH each  lane holding-register contents
- out_valid  output  8  bit k = lane k holds an undelivered word
- out_ready  input  8  bit k = lane k consumer takes the word this cycle
- count  output  CNT_W  number of words accepted since reset, wraps

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values (on the clk edge with reset=1): o0..o7 = 0, out_valid = 8'h00, count = 0. Reset has priority over every transfer in that cycle.
- Reset mid-operation: undelivered words are discarded without notification.
- Lane state: each lane k has exactly two states.
  - EMPTY (out_valid[k]=0).
  - FULL (out_valid[k]=1).
- Drain: a drain of lane k occurs when out_valid[k] & out_ready[k]. out_ready[k] while EMPTY has no effect.
- Ready rule: in_ready = ~out_valid[sel] | out_ready[sel].
  - A full lane that drains this cycle can accept a new word in the same cycle (pass-through refill).
  - in_ready is a combinational function of sel, out_valid and out_ready. It has no dependency on in_valid.
- Accept: an accept occurs when in_valid & in_ready. On that edge:
  - lane sel data <= in;
  - out_valid[sel] <= 1;
  - count <= count + 1, modulo 2^CNT_W (0xFFFF -> 0x0000 at the default width).
- Latency: a word is visible on o<sel> with out_valid set one cycle after acceptance. Minimum end-to-end latency is one cycle.
- Lane transitions:
  - EMPTY -> FULL on accept to lane k.
  - FULL -> EMPTY on drain without accept to lane k.
  - FULL -> FULL with new data on simultaneous drain and accept to lane k.
  - FULL with no drain and no accept: holds.
- Concurrency: drains on different lanes are independent and may all occur in the same cycle. Only the lane selected by sel can be written in a cycle.
- Data hold: o<k> keeps its last written value after a drain; it is not cleared. Consumers must qualify data with out_valid[k].
- Stall: a blocked producer (in_valid=1, in_ready=0) is not accepted. count and all lanes are unchanged by the attempt. The producer may change sel while stalled, and ready is re-evaluated for the new sel.
- Handshake contract: out_valid[k] never drops without a drain or reset. o<k> is stable while out_valid[k]=1 and out_ready[k]=0.

Optional Feature:
- Macro: DMUX_BROADCAST_EN.
- With the macro defined:
  - Extra input port bcast (1 bit).
  - When bcast=1, the word targets all eight lanes and sel is ignored.
  - in_ready = AND over k of (~out_valid[k] | out_ready[k]).
  - On accept, all eight lanes load in and set valid; count increments by 1, not 8.
  - When bcast=0, behaviour is exactly as above.
- Without the macro: no bcast port and no broadcast logic.

Test Plan:
- Reset, then in=16'hA5A5, sel=3, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=8'h08, o3=16'hA5A5, count=1, all other lanes 0.
- Lane 3 full, out_ready=0, offer in=16'h1234 to sel=3 -> in_ready=0; lane 3 still 16'hA5A5, count unchanged. Same cycle, sel=5 -> in_ready=1 and o5=16'h1234 next cycle.
- Lane 3 full, out_ready[3]=1, in=16'hBEEF, sel=3, in_valid=1 in the same cycle -> in_ready=1; next cycle out_valid[3]=1, o3=16'hBEEF (pass-through refill).
- Fill all 8 lanes with values 16'h0000..16'h0007, then pulse out_ready=8'hFF for one cycle -> out_valid goes 8'hFF -> 8'h00 and o0..o7 retain 0..7.
- Preload count to 16'hFFFF by accepting 65535 words, then accept one more -> count=0. Assert reset while lanes are full -> next cycle out_valid=0, all o=0, count=0.
- With DMUX_BROADCAST_EN: lanes empty, bcast=1, in=16'h00FF -> out_valid=8'hFF, all o=16'h00FF, count+1. Retry with lane 2 full and not draining -> in_ready=0.
